// File: rtl/inst_mem_param.sv
// Instruction memory: clears itself after every reset, then serves program loads and fetches.
// Fetch latency 1 cycle; req_ready is low while clearing and requests made then are dropped, not queued.
module inst_mem_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_err,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] inst_address,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] read_data,
  output logic              addr_err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is still representable in the bound check.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  clr_cnt, clr_cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [DATA_W-1:0] mem_wdat;
  logic              load_in_range;
  logic              fetch_in_range;
  logic              fetch_acc;

  assign load_in_range  = {1'b0, load_addr} < DEPTH_X;
  assign fetch_in_range = {1'b0, inst_address} < DEPTH_X;
  assign fetch_acc      = req_valid & req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    mem_we      = 1'b0;
    mem_widx    = load_addr[IDX_W-1:0];
    mem_wdat    = load_data;
    busy        = 1'b0;
    req_ready   = 1'b0;
    case (state)
      CLEAR: begin
        busy     = 1'b1;
        mem_we   = 1'b1;
        mem_widx = clr_cnt;
        mem_wdat = '0;
        if (clr_cnt == IDX_W'(DEPTH - 1)) begin
          state_nxt   = READY;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + IDX_W'(1);
        end
      end
      READY: begin
        req_ready = 1'b1;
        mem_we    = load_en & load_in_range;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // Storage carries no reset; the clear walk initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdat;
  end

  // Reads sample mem before this edge's write lands, giving read-before-write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      read_data <= '0;
      addr_err  <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      rsp_valid <= fetch_acc;
      addr_err  <= fetch_acc & ~fetch_in_range;
      load_err  <= (state == READY) & load_en & ~load_in_range;
      if (fetch_acc)
        read_data <= fetch_in_range ? mem[inst_address[IDX_W-1:0]] : '0;
    end
  end

endmodule

// File: tb/tb_inst_mem_param.sv
// Directed bench for inst_mem_param (DEPTH=256): clear timing, loads, fetches, range errors, reset abort.
module tb_inst_mem_param;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic [15:0] load_addr;
  logic [31:0] load_data;
  logic        load_err;
  logic        req_valid;
  logic [15:0] inst_address;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] read_data;
  logic        addr_err;
  logic        busy;

  int vecs = 0;
  int miscompares = 0;
  int n_clr;
  int n_rsp;

  inst_mem_param #(.DATA_W(32), .ADDR_W(16), .DEPTH(256)) dut (
    .clk(clk), .rst(rst),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .load_err(load_err),
    .req_valid(req_valid), .inst_address(inst_address), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .read_data(read_data), .addr_err(addr_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until busy drops (bounded); also counts any rsp_valid seen meanwhile.
  task automatic wait_clear(output int n, output int rsp_seen);
    n = 0;
    rsp_seen = 0;
    do begin
      tick();
      n++;
      if (rsp_valid) rsp_seen++;
    end while (busy && n < 1000);
  endtask

  task automatic fetch_chk(input string tag, input logic [31:0] exp_dat, input logic exp_err);
    chk({tag, "_vld"}, 64'(rsp_valid), 64'(1));
    chk({tag, "_dat"}, 64'(read_data), 64'(exp_dat));
    chk({tag, "_err"}, 64'(addr_err), 64'(exp_err));
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    req_valid = 1'b0; inst_address = '0;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'(1));
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_read_data", 64'(read_data), 64'(0));
    chk("rst_addr_err", 64'(addr_err), 64'(0));
    chk("rst_load_err", 64'(load_err), 64'(0));

    // Clear lasts exactly DEPTH cycles after release.
    rst = 1'b0;
    wait_clear(n_clr, n_rsp);
    chk("clear_cycles", 64'(n_clr), 64'(256));
    chk("ready_after_clear", 64'(req_ready), 64'(1));

    // Cleared words read as zero, back to back.
    req_valid = 1'b1; inst_address = 16'd0;   tick(); fetch_chk("clr0", 32'h0, 1'b0);
    inst_address = 16'd128;                   tick(); fetch_chk("clr128", 32'h0, 1'b0);
    inst_address = 16'd255;                   tick(); fetch_chk("clr255", 32'h0, 1'b0);
    req_valid = 1'b0;                         tick();
    chk("idle_rsp_valid", 64'(rsp_valid), 64'(0));

    // Load then fetch address 0.
    load_en = 1'b1; load_addr = 16'd0; load_data = 32'h2000_0004; tick();
    chk("load0_no_rsp", 64'(rsp_valid), 64'(0));
    load_en = 1'b0; req_valid = 1'b1; inst_address = 16'd0; tick();
    fetch_chk("ld0", 32'h2000_0004, 1'b0);
    req_valid = 1'b0; tick();
    chk("hold_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("hold_read_data", 64'(read_data), 64'h2000_0004);
    chk("hold_addr_err", 64'(addr_err), 64'(0));

    // Same-edge load and fetch returns the old word.
    load_en = 1'b1; load_addr = 16'd5; load_data = 32'hDEAD_BEEF;
    req_valid = 1'b1; inst_address = 16'd5; tick();
    fetch_chk("rbw_old", 32'h0, 1'b0);
    load_en = 1'b0; tick();
    fetch_chk("rbw_new", 32'hDEAD_BEEF, 1'b0);

    // Out-of-range fetch and load at the same edge.
    load_en = 1'b1; load_addr = 16'd300; load_data = 32'h5555_AAAA;
    inst_address = 16'd256; tick();
    fetch_chk("oor_fetch", 32'h0, 1'b1);
    chk("oor_load_err", 64'(load_err), 64'(1));
    load_en = 1'b0; inst_address = 16'd44; tick();
    chk("load_err_pulse", 64'(load_err), 64'(0));
    fetch_chk("no_wrap44", 32'h0, 1'b0);
    inst_address = 16'hFFFF; tick();
    fetch_chk("oor_ffff", 32'h0, 1'b1);
    req_valid = 1'b0; tick();
    chk("oor_err_drop", 64'(addr_err), 64'(0));

    // Load 1..3, then back-to-back fetches return them in order.
    load_en = 1'b1;
    load_addr = 16'd1; load_data = 32'h1111_1111; tick();
    load_addr = 16'd2; load_data = 32'h2222_2222; tick();
    load_addr = 16'd3; load_data = 32'h3333_3333; tick();
    load_en = 1'b0; req_valid = 1'b1;
    inst_address = 16'd1; tick(); fetch_chk("b2b1", 32'h1111_1111, 1'b0);
    inst_address = 16'd2; tick(); fetch_chk("b2b2", 32'h2222_2222, 1'b0);
    inst_address = 16'd3; tick(); fetch_chk("b2b3", 32'h3333_3333, 1'b0);
    inst_address = 16'd0; tick(); fetch_chk("b2b0", 32'h2000_0004, 1'b0);

    // Reset with a fetch in flight: response is killed, requests during clear are dropped.
    inst_address = 16'd5; @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("inflight_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("inflight_read_data", 64'(read_data), 64'(0));
    chk("inflight_busy", 64'(busy), 64'(1));
    tick();
    rst = 1'b0;
    wait_clear(n_clr, n_rsp);
    chk("clear_cycles_2", 64'(n_clr), 64'(256));
    chk("dropped_during_clear", 64'(n_rsp), 64'(0));
    req_valid = 1'b0;

    // Reset at clear count 100: clear restarts from zero.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    chk("mid_clear_busy", 64'(busy), 64'(1));
    rst = 1'b1; #1;
    chk("mid_clear_rst_ready", 64'(req_ready), 64'(0));
    tick();
    rst = 1'b0;
    wait_clear(n_clr, n_rsp);
    chk("clear_cycles_3", 64'(n_clr), 64'(256));
    chk("ready_after_abort", 64'(req_ready), 64'(1));

    // Contents written before reset are wiped by the clear.
    req_valid = 1'b1;
    inst_address = 16'd5; tick(); fetch_chk("wiped5", 32'h0, 1'b0);
    inst_address = 16'd3; tick(); fetch_chk("wiped3", 32'h0, 1'b0);
    req_valid = 1'b0; tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
